// File: rtl/pipe_debug_ctrl_pkg.sv
// Shared encodings for the pipeline run/halt/step debug controller.
// Optional trace outputs are enabled with PIPE_DBG_TRACE_EN.
package pipe_debug_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_RUN     = 3'd1,
        CMD_HALT    = 3'd2,
        CMD_STEP    = 3'd3,
        CMD_SET_BRK = 3'd4,
        CMD_CLR_BRK = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int brk_idx_width(input int n_brk);
        return (n_brk > 1) ? $clog2(n_brk) : 1;
    endfunction

endpackage

// File: rtl/pipe_debug_ctrl_if.sv
// Command port from the debug micro/SPI bridge: valid/ready handshake plus payload.
interface pipe_debug_ctrl_if #(
    parameter int NB_BITS = 32,
    parameter int NB_IDX  = 1
);
    logic               i_cmd_valid;
    logic [2:0]         i_cmd;
    logic [NB_BITS-1:0] i_cmd_arg;
    logic [NB_IDX-1:0]  i_brk_idx;
    logic               o_cmd_ready;

    modport master (
        output i_cmd_valid, i_cmd, i_cmd_arg, i_brk_idx,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_cmd_arg, i_brk_idx,
        output o_cmd_ready
    );
endinterface

// File: rtl/pipe_debug_ctrl_brk_match.sv
// PC breakpoint bank: N_BRK address/valid slots with one write port and an OR-reduced match.
module pipe_debug_ctrl_brk_match #(
    parameter int NB_BITS = 32,
    parameter int N_BRK   = 2,
    parameter int NB_IDX  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [NB_IDX-1:0]  i_wr_idx,
    input  logic [NB_BITS-1:0] i_wr_pc,
    input  logic               i_clr,
    input  logic [NB_BITS-1:0] i_pc,
    output logic               o_match
);

    logic [NB_BITS-1:0] brk_pc [N_BRK];
    logic [N_BRK-1:0]   brk_vld;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            brk_vld <= '0;
            for (int i = 0; i < N_BRK; i++) begin
                brk_pc[i] <= '0;
            end
        end else begin
            if (i_clr) begin
                brk_vld <= '0;
            end
            for (int i = 0; i < N_BRK; i++) begin
                if (i_wr_en && (i_wr_idx == NB_IDX'(i))) begin
                    brk_pc[i]  <= i_wr_pc;
                    brk_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < N_BRK; i++) begin
            if (brk_vld[i] && (brk_pc[i] == i_pc)) begin
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_debug_ctrl.sv
// Run/halt/step controller driving per-stage pipeline enables for the debug port.
// Define PIPE_DBG_TRACE_EN to get the enabled-cycle counter and halt-PC capture.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_HALT  | pipeline frozen, accepts commands
// ST_RUN   | free running until HALT cmd, halt opcode or breakpoint
// ST_STEP  | runs a fixed number of cycles, then halts
// ST_DRAIN | fetch stopped, younger stages retire in-flight instructions
module pipe_debug_ctrl
    import pipe_debug_ctrl_pkg::*;
#(
    parameter int NB_BITS  = 32,
    parameter int N_STAGES = 5,
    parameter int N_BRK    = 2,
    parameter int NB_STEP  = 16,
    parameter int NB_IDX   = brk_idx_width(N_BRK)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    pipe_debug_ctrl_if.slave    cmd_if,
    input  logic [NB_BITS-1:0]  i_pc,
    input  logic                i_halt_instr,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic                o_debug,
    output logic [1:0]          o_state,
    output logic                o_brk_hit,
    output logic                o_done,
    output logic [NB_BITS-1:0]  o_cycle_cnt,
    output logic [NB_BITS-1:0]  o_halt_pc
);

    state_t               state_q, state_d;
    logic [NB_STEP-1:0]   cnt_q, cnt_d;
    logic                 skip_q;
    logic                 brk_hit_q, done_q;
    logic                 cmd_ready;
    logic                 cmd_acc;
    logic                 brk_match;
    logic                 brk_fire;
    logic [NB_STEP-1:0]   step_arg;

    assign cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
    assign cmd_acc   = cmd_if.i_cmd_valid && cmd_ready;
    assign step_arg  = cmd_if.i_cmd_arg[NB_STEP-1:0];

    pipe_debug_ctrl_brk_match #(
        .NB_BITS (NB_BITS),
        .N_BRK   (N_BRK),
        .NB_IDX  (NB_IDX)
    ) u_brk_match (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_en  (cmd_acc && (cmd_if.i_cmd == CMD_SET_BRK)),
        .i_wr_idx (cmd_if.i_brk_idx),
        .i_wr_pc  (cmd_if.i_cmd_arg),
        .i_clr    (cmd_acc && (cmd_if.i_cmd == CMD_CLR_BRK)),
        .i_pc     (i_pc),
        .o_match  (brk_match)
    );

    // The skip flag masks the first cycle after resuming so the breakpoint PC itself can be fetched.
    assign brk_fire = brk_match && !skip_q &&
                      ((state_q == ST_RUN) || (state_q == ST_STEP));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o_stage_en = '0;
        case (state_q)
            ST_HALT: begin
                if (cmd_acc && (cmd_if.i_cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && (cmd_if.i_cmd == CMD_STEP)) begin
                    state_d = ST_STEP;
                    cnt_d   = (step_arg == '0) ? NB_STEP'(1) : step_arg;
                end
            end
            ST_RUN: begin
                o_stage_en = brk_fire ? '0 : '1;
                if (brk_fire) begin
                    state_d = ST_HALT;
                end else if ((cmd_acc && (cmd_if.i_cmd == CMD_HALT)) || i_halt_instr) begin
                    state_d = ST_DRAIN;
                    cnt_d   = NB_STEP'(N_STAGES - 1);
                end
            end
            ST_STEP: begin
                o_stage_en = brk_fire ? '0 : '1;
                if (brk_fire || (cnt_q <= NB_STEP'(1))) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - NB_STEP'(1);
                end
            end
            ST_DRAIN: begin
                o_stage_en    = '1;
                o_stage_en[0] = 1'b0;
                if (cnt_q <= NB_STEP'(1)) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - NB_STEP'(1);
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_HALT;
            cnt_q     <= '0;
            skip_q    <= 1'b0;
            brk_hit_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            skip_q    <= (state_q == ST_HALT) && (state_d != ST_HALT);
            brk_hit_q <= brk_fire;
            done_q    <= (state_q != ST_HALT) && (state_d == ST_HALT);
        end
    end

`ifdef PIPE_DBG_TRACE_EN
    logic [NB_BITS-1:0] cycle_cnt_q;
    logic [NB_BITS-1:0] halt_pc_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cycle_cnt_q <= '0;
            halt_pc_q   <= '0;
        end else begin
            if (o_stage_en[N_STAGES-1]) begin
                cycle_cnt_q <= cycle_cnt_q + NB_BITS'(1);
            end
            if ((state_q != ST_HALT) && (state_d == ST_HALT)) begin
                halt_pc_q <= i_pc;
            end
        end
    end

    assign o_cycle_cnt = cycle_cnt_q;
    assign o_halt_pc   = halt_pc_q;
`else
    assign o_cycle_cnt = '0;
    assign o_halt_pc   = '0;
`endif

    assign cmd_if.o_cmd_ready = cmd_ready;
    assign o_debug            = (state_q != ST_RUN);
    assign o_state            = state_q;
    assign o_brk_hit          = brk_hit_q;
    assign o_done             = done_q;

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Directed bench for pipe_debug_ctrl: run/halt/drain/step, breakpoints, priority and reset.
module tb_pipe_debug_ctrl;
    import pipe_debug_ctrl_pkg::*;

    localparam int NB_BITS  = 32;
    localparam int N_STAGES = 5;
    localparam int N_BRK    = 2;
    localparam int NB_STEP  = 16;
    localparam int NB_IDX   = 1;

`ifdef PIPE_DBG_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [NB_BITS-1:0]  i_pc;
    logic                i_halt_instr;
    logic [N_STAGES-1:0] o_stage_en;
    logic                o_debug;
    logic [1:0]          o_state;
    logic                o_brk_hit;
    logic                o_done;
    logic [NB_BITS-1:0]  o_cycle_cnt;
    logic [NB_BITS-1:0]  o_halt_pc;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_debug_ctrl_if #(.NB_BITS(NB_BITS), .NB_IDX(NB_IDX)) cmd_if ();

    pipe_debug_ctrl #(
        .NB_BITS  (NB_BITS),
        .N_STAGES (N_STAGES),
        .N_BRK    (N_BRK),
        .NB_STEP  (NB_STEP),
        .NB_IDX   (NB_IDX)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cmd_if       (cmd_if),
        .i_pc         (i_pc),
        .i_halt_instr (i_halt_instr),
        .o_stage_en   (o_stage_en),
        .o_debug      (o_debug),
        .o_state      (o_state),
        .o_brk_hit    (o_brk_hit),
        .o_done       (o_done),
        .o_cycle_cnt  (o_cycle_cnt),
        .o_halt_pc    (o_halt_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input cmd_t cmd, input logic [NB_BITS-1:0] arg, input logic [NB_IDX-1:0] idx);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = cmd;
        cmd_if.i_cmd_arg   = arg;
        cmd_if.i_brk_idx   = idx;
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd       = CMD_NOP;
        cmd_if.i_cmd_arg   = '0;
        cmd_if.i_brk_idx   = '0;
        i_pc               = '0;
        i_halt_instr       = 1'b0;
        i_rst              = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        chk("rst_state", o_state, 0);
        chk("rst_en", o_stage_en, 5'h00);
        chk("rst_debug", o_debug, 1);
        chk("rst_ready", cmd_if.o_cmd_ready, 1);
        chk("rst_pulses", {o_brk_hit, o_done}, 2'b00);
        chk("rst_trace", {o_cycle_cnt, o_halt_pc}, 64'h0);

        // RUN, then HALT cmd drains for N_STAGES-1 cycles
        send(CMD_RUN, 0, 0);
        chk("run_state", o_state, 1);
        chk("run_en", o_stage_en, 5'h1f);
        chk("run_debug", o_debug, 0);
        tick();
        tick();
        send(CMD_HALT, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_state", o_state, 3);
            chk("drain_en", o_stage_en, 5'h1e);
            chk("drain_ready", cmd_if.o_cmd_ready, 0);
            tick();
        end
        chk("drain_end_state", o_state, 0);
        chk("drain_end_en", o_stage_en, 5'h00);
        chk("drain_done", o_done, 1);
        chk("cycle_cnt", o_cycle_cnt, TRACE ? 7 : 0);
        tick();
        chk("done_pulse_once", o_done, 0);

        // STEP 3 and STEP 0 (treated as 1)
        send(CMD_STEP, 3, 0);
        for (int k = 0; k < 3; k++) begin
            chk("step3_state", o_state, 2);
            chk("step3_en", o_stage_en, 5'h1f);
            tick();
        end
        chk("step3_end", o_state, 0);
        chk("step3_done", o_done, 1);
        send(CMD_STEP, 0, 0);
        chk("step0_en", o_stage_en, 5'h1f);
        tick();
        chk("step0_end", o_state, 0);

        // breakpoint at 0x40 freezes immediately
        send(CMD_SET_BRK, 32'h40, 0);
        i_pc = 32'h10;
        send(CMD_RUN, 0, 0);
        chk("bp_run_en", o_stage_en, 5'h1f);
        tick();
        i_pc = 32'h40;
        #1;
        chk("bp_hit_en", o_stage_en, 5'h00);
        tick();
        chk("bp_state", o_state, 0);
        chk("bp_hit", o_brk_hit, 1);
        chk("bp_done", o_done, 1);
        chk("bp_halt_pc", o_halt_pc, TRACE ? 32'h40 : 32'h0);
        tick();
        chk("bp_hit_pulse", o_brk_hit, 0);

        // resume at the breakpoint PC: skipped for one cycle only
        send(CMD_RUN, 0, 0);
        chk("skip_state", o_state, 1);
        chk("skip_en", o_stage_en, 5'h1f);
        tick();
        chk("rehit_en", o_stage_en, 5'h00);
        tick();
        chk("rehit_state", o_state, 0);
        chk("rehit_hit", o_brk_hit, 1);

        // breakpoint beats HALT cmd and halt opcode
        i_pc = 32'h44;
        send(CMD_RUN, 0, 0);
        tick();
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = CMD_HALT;
        i_halt_instr       = 1'b1;
        i_pc               = 32'h40;
        #1;
        chk("prio_en", o_stage_en, 5'h00);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        i_halt_instr       = 1'b0;
        #1;
        chk("prio_state", o_state, 0);
        chk("prio_hit", o_brk_hit, 1);

        // halt opcode drains; breakpoints ignored while draining
        i_pc = 32'h100;
        send(CMD_RUN, 0, 0);
        tick();
        i_halt_instr = 1'b1;
        tick();
        i_halt_instr = 1'b0;
        chk("hinstr_state", o_state, 3);
        i_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hinstr_drain_en", o_stage_en, 5'h1e);
            tick();
        end
        chk("hinstr_end", o_state, 0);
        chk("hinstr_no_hit", o_brk_hit, 0);

        // STEP ignores halt opcode; held command waits for ready
        i_pc = 32'h80;
        send(CMD_STEP, 2, 0);
        i_halt_instr       = 1'b1;
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = CMD_RUN;
        #1;
        chk("hold_ready", cmd_if.o_cmd_ready, 0);
        chk("hold_state", o_state, 2);
        tick();
        chk("hold_state2", o_state, 2);
        tick();
        chk("hold_step_end", o_state, 0);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        i_halt_instr       = 1'b0;
        #1;
        chk("hold_consumed", o_state, 1);
        send(CMD_HALT, 0, 0);
        repeat (4) tick();
        chk("hold_halted", o_state, 0);

        // reset in the middle of a long STEP
        send(CMD_STEP, 100, 0);
        repeat (3) tick();
        chk("rst_mid_pre", o_state, 2);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        #1;
        chk("rst_mid_state", o_state, 0);
        chk("rst_mid_en", o_stage_en, 5'h00);
        send(CMD_RUN, 0, 0);
        tick();
        i_pc = 32'h40;
        #1;
        chk("rst_brk_cleared", o_stage_en, 5'h1f);
        tick();
        chk("rst_brk_run", o_state, 1);

        // SET_BRK in RUN takes effect next cycle; CLR_BRK removes it
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = CMD_SET_BRK;
        cmd_if.i_cmd_arg   = 32'h200;
        cmd_if.i_brk_idx   = 1'b1;
        i_pc               = 32'h200;
        #1;
        chk("set_same_cycle", o_stage_en, 5'h1f);
        tick();
        cmd_if.i_cmd_valid = 1'b0;
        #1;
        chk("set_next_cycle", o_stage_en, 5'h00);
        tick();
        chk("slot1_hit", o_brk_hit, 1);
        send(CMD_CLR_BRK, 0, 0);
        send(CMD_RUN, 0, 0);
        tick();
        chk("clr_en", o_stage_en, 5'h1f);
        chk("clr_state", o_state, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
